// File: rtl/exp_stage_ctrl.sv
// exp_stage_ctrl: sequences input-buffer reads through the four exp lanes and
// writes each 4-word result to the output BRAM, pulsing done at job end.
module exp_stage_ctrl #(
   parameter int BUF_AWIDTH = 4,
   parameter int OUT_AWIDTH = 9,
   parameter int RAM_LAT    = 1,
   parameter int EXP_LAT    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [BUF_AWIDTH:0]   num_entries,
   input  logic [BUF_AWIDTH-1:0] rd_base,
   input  logic [OUT_AWIDTH-1:0] wr_base,
   output logic                  rd_en,
   output logic [BUF_AWIDTH-1:0] rd_addr,
   output logic                  stage_run,
   output logic                  stage_run2,
   output logic                  wr_en,
   output logic [OUT_AWIDTH-1:0] wr_addr,
   output logic                  busy,
   output logic                  done
);
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
   localparam int L = RAM_LAT + EXP_LAT - 1;
   localparam logic [BUF_AWIDTH:0] NMAX = {1'b1, {BUF_AWIDTH{1'b0}}};
   logic [1:0] state;
   logic [BUF_AWIDTH:0] n_q, k, n_in;
   logic [BUF_AWIDTH-1:0] rd_base_q, off;
   logic [OUT_AWIDTH-1:0] wr_base_q;
   logic [L-1:0] v;
   logic [L-1:0][BUF_AWIDTH-1:0] o;
   always_comb n_in = num_entries > NMAX ? NMAX : num_entries;
   // the issue offset is recovered from the read address rather than kept separately
   assign off = rd_addr - rd_base_q;
   assign stage_run = v[RAM_LAT-1];
   assign stage_run2 = v[RAM_LAT];
   assign busy = state != IDLE;
   assign done = state == DONE;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         n_q <= '0;
         k <= '0;
         rd_base_q <= '0;
         wr_base_q <= '0;
         rd_en <= 1'b0;
         rd_addr <= '0;
         v <= '0;
         o <= '0;
         wr_en <= 1'b0;
         wr_addr <= '0;
      end else begin
         v <= {v[L-2:0], rd_en};
         o <= {o[L-2:0], off};
         wr_en <= v[L-1];
         if (v[L-1]) wr_addr <= wr_base_q + OUT_AWIDTH'(o[L-1]);
         if (state == IDLE) begin
            if (start) begin
               n_q <= n_in;
               rd_base_q <= rd_base;
               wr_base_q <= wr_base;
               k <= {{BUF_AWIDTH{1'b0}}, 1'b1};
               rd_en <= n_in != '0;
               if (n_in != '0) rd_addr <= rd_base;
               state <= n_in != '0 ? RUN : DONE;
            end
         end else if (state == RUN) begin
            rd_en <= k != n_q;
            if (k != n_q) begin
               rd_addr <= rd_base_q + k[BUF_AWIDTH-1:0];
               k <= k + 1'b1;
            end else state <= DRAIN;
         end else if (state == DRAIN) begin
            if (v == '0) state <= DONE;
         end else state <= IDLE;
      end
   end
endmodule

// File: tb/tb_exp_stage_ctrl.sv
// tb_exp_stage_ctrl: directed jobs push expected read/stage/write/done events
// into queues; a negedge monitor pops and compares as the DUT emits them.
module tb_exp_stage_ctrl;
   typedef struct {
      int c;
      int a;
   } ev_t;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [4:0] num_entries = '0;
   logic [3:0] rd_base = '0, rd_addr;
   logic [8:0] wr_base = '0, wr_addr;
   logic rd_en, stage_run, stage_run2, wr_en, busy, done;
   int cyc = 0, errors = 0, checks = 0, c0;
   ev_t rdq[$], wrq[$];
   int srq[$], sr2q[$], dnq[$];

   exp_stage_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .num_entries(num_entries),
      .rd_base(rd_base), .wr_base(wr_base), .rd_en(rd_en), .rd_addr(rd_addr),
      .stage_run(stage_run), .stage_run2(stage_run2), .wr_en(wr_en),
      .wr_addr(wr_addr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // expected events of a job whose start is seen in cycle s; only events before lim
   task automatic push_job(input int n, input int rb, input int wb, input int s, input int lim);
      int ne;
      ne = n > 16 ? 16 : n;
      for (int i = 0; i < ne; i++) begin
         if (s + 1 + i < lim) rdq.push_back('{s + 1 + i, (rb + i) % 16});
         if (s + 2 + i < lim) srq.push_back(s + 2 + i);
         if (s + 3 + i < lim) sr2q.push_back(s + 3 + i);
         if (s + 4 + i < lim) wrq.push_back('{s + 4 + i, (wb + i) % 512});
      end
      if (s + (ne == 0 ? 1 : ne + 4) < lim) dnq.push_back(s + (ne == 0 ? 1 : ne + 4));
   endtask

   task automatic go(input int n, input int rb, input int wb, input int lim);
      c0 = cyc;
      start = 1'b1;
      num_entries = 5'(n);
      rd_base = 4'(rb);
      wr_base = 9'(wb);
      push_job(n, rb, wb, c0, lim);
   endtask

   task automatic chk_quiet(input string name);
      chk({name, "_out"}, {rd_en, stage_run, stage_run2, wr_en, busy, done}, 0);
   endtask

   always @(negedge clk) if (!reset) begin
      ev_t e;
      int c;
      if (rd_en) begin
         if (rdq.size() > 0) begin
            e = rdq.pop_front();
            chk("rd_cycle", cyc, e.c);
            chk("rd_addr", int'(rd_addr), e.a);
         end else chk("rd_unexpected", cyc, -1);
      end
      if (wr_en) begin
         if (wrq.size() > 0) begin
            e = wrq.pop_front();
            chk("wr_cycle", cyc, e.c);
            chk("wr_addr", int'(wr_addr), e.a);
         end else chk("wr_unexpected", cyc, -1);
      end
      if (stage_run) begin
         if (srq.size() > 0) begin
            c = srq.pop_front();
            chk("stage_run_cycle", cyc, c);
         end else chk("stage_run_unexpected", cyc, -1);
      end
      if (stage_run2) begin
         if (sr2q.size() > 0) begin
            c = sr2q.pop_front();
            chk("stage_run2_cycle", cyc, c);
         end else chk("stage_run2_unexpected", cyc, -1);
      end
      if (done) begin
         chk("done_busy", int'(busy), 1);
         if (dnq.size() > 0) begin
            c = dnq.pop_front();
            chk("done_cycle", cyc, c);
         end else chk("done_unexpected", cyc, -1);
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk_quiet("reset");
      chk("reset_addrs", {rd_addr, wr_addr}, 0);
      reset = 1'b0;
      @(negedge clk);
      // basic job
      go(4, 0, 0, 1 << 30);
      @(negedge clk) start = 1'b0;
      chk("basic_busy", int'(busy), 1);
      repeat (10) @(negedge clk);
      chk("basic_idle_busy", int'(busy), 0);
      chk("basic_hold_wr_addr", int'(wr_addr), 3);
      chk("basic_hold_rd_addr", int'(rd_addr), 3);
      // empty job
      go(0, 5, 5, 1 << 30);
      @(negedge clk) start = 1'b0;
      chk("empty_busy", int'(busy), 1);
      @(negedge clk);
      chk("empty_busy_after", int'(busy), 0);
      repeat (3) @(negedge clk);
      // address wrap
      go(16, 12, 510, 1 << 30);
      @(negedge clk) start = 1'b0;
      repeat (25) @(negedge clk);
      // start during RUN is ignored
      go(4, 2, 40, 1 << 30);
      @(negedge clk) start = 1'b0;
      @(negedge clk);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (10) @(negedge clk);
      // start held high: next job from IDLE one cycle after DONE
      go(4, 3, 100, 1 << 30);
      push_job(4, 3, 100, c0 + 9, 1 << 30);
      repeat (9) @(negedge clk);
      chk("held_idle_gap", int'(busy), 0);
      @(negedge clk) start = 1'b0;
      chk("held_second_busy", int'(busy), 1);
      repeat (12) @(negedge clk);
      // asynchronous reset mid-job
      go(4, 5, 200, cyc + 5);
      @(negedge clk) start = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk_quiet("midreset");
      @(negedge clk) reset = 1'b0;
      repeat (4) @(negedge clk);
      chk_quiet("post_reset");
      go(4, 15, 511, 1 << 30);
      @(negedge clk) start = 1'b0;
      repeat (10) @(negedge clk);
      // clamp
      go(20, 7, 0, 1 << 30);
      @(negedge clk) start = 1'b0;
      repeat (25) @(negedge clk);
      chk("rdq_left", rdq.size(), 0);
      chk("wrq_left", wrq.size(), 0);
      chk("srq_left", srq.size(), 0);
      chk("sr2q_left", sr2q.size(), 0);
      chk("dnq_left", dnq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
